// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and instruction-loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int         INSTR_W  = 32;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[31:26] == OPC_HALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Big-endian byte-to-word assembler (shift register + 2-bit count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               xfer,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_ready
);

    logic [INSTR_W-1:0] r_word;
    logic [1:0]         r_cnt;

    // First byte ends up in the top lane after four left shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= 2'd0;
        end else if (clr) begin
            r_cnt  <= 2'd0;
        end else if (xfer) begin
            r_word <= {r_word[INSTR_W-9:0], byte_in};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign word       = r_word;
    assign word_ready = xfer && (r_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module      : instr_mem_loader
// Description : Byte-stream to instruction-memory loader; stops on halt or full.
//               Optional INSTR_LOADER_CHECKSUM_EN adds an XOR checksum of bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow_err,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    ld_state_t          r_state;
    ld_state_t          w_state_nxt;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_ovf;
    logic               w_start_ok;
    logic               w_xfer;
    logic               w_word_ready;
    logic [INSTR_W-1:0] w_word;
    logic               w_halt;
    logic               w_last;

    assign w_xfer = in_valid && in_ready;
    assign w_halt = is_halt(w_word);
    assign w_last = (r_waddr == c_last_addr);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_start_ok),
        .xfer       (w_xfer),
        .byte_in    (in_data),
        .word       (w_word),
        .word_ready (w_word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        case (r_state)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    w_state_nxt = LD_RECV;
                    w_start_ok  = 1'b1;
                end
            end
            LD_RECV: begin
                if (w_word_ready) begin
                    w_state_nxt = LD_WRITE;
                end
            end
            LD_WRITE: begin
                if (w_halt || w_last) begin
                    w_state_nxt = LD_DONE;
                end else begin
                    w_state_nxt = LD_RECV;
                end
            end
            default: begin
                w_state_nxt = LD_IDLE;
            end
        endcase
    end

    // Address advances only after a non-final write, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_ovf   <= 1'b0;
        end else if (w_start_ok) begin
            r_waddr <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == LD_WRITE) begin
            if (!w_halt && w_last) begin
                r_ovf <= 1'b1;
            end else if (!w_halt) begin
                r_waddr <= r_waddr + 1'b1;
            end
        end
    end

    assign in_ready     = (r_state == LD_RECV);
    assign mem_we       = (r_state == LD_WRITE);
    assign busy         = (r_state == LD_RECV) || (r_state == LD_WRITE);
    assign done         = (r_state == LD_DONE);
    assign overflow_err = r_ovf;
    assign mem_waddr    = r_waddr;
    assign mem_wdata    = w_word;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 8'h00;
        end else if (w_start_ok) begin
            r_checksum <= 8'h00;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Randomized scoreboard bench for instr_mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow_err;
    logic [7:0]        checksum;

    instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] stim_words[$];
    int          n_vec     = 0;
    int          n_err     = 0;
    int          cycle     = 0;
    int          last_xfer = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_cs(input logic [7:0] cs);
`ifdef INSTR_LOADER_CHECKSUM_EN
        return cs;
`else
        return 8'h00;
`endif
    endfunction

    // Monitor: every write strobe is matched against the scoreboard queue.
    wr_t mon_e;
    always @(negedge clk) begin
        cycle++;
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready) last_xfer = cycle;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_waddr, mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 64'(mem_waddr), 64'(mon_e.addr));
                    check("write_data", 64'(mem_wdata), 64'(mon_e.data));
                    check("write_latency", 64'(cycle - last_xfer), 64'd1);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit allow_start);
        int gap;
        int t;
        bit acc;
        gap = $urandom_range(0, 2);
        t   = 0;
        acc = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && t < 50) begin
            start = allow_start && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_accept_timeout: got in_ready low for 50 cycles, required acceptance");
        end
    endtask

    // Reference model: word i goes to address i; stop after a halt word or the last address.
    task automatic run_load();
        int          n_used;
        bit          exp_ovf;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        int          t;
        n_used  = 0;
        exp_ovf = 1'b0;
        cs      = 8'h00;
        for (int i = 0; i < stim_words.size(); i++) begin
            exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: stim_words[i]});
            n_used = i + 1;
            w = stim_words[i];
            if (w[31:26] == 6'h3F) break;
            if (i == DEPTH - 1) begin
                exp_ovf = 1'b1;
                break;
            end
        end
        w        = stim_words[0];
        start    = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = w[31:24];
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int wi = 0; wi < n_used; wi++) begin
            w = stim_words[wi];
            for (int bi = 0; bi < 4; bi++) begin
                b = w[31 - 8*bi -: 8];
                send_byte(b, 1'b1);
                cs ^= b;
            end
            check("checksum_running", 64'(checksum), 64'(exp_cs(cs)));
        end
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("done", 64'(done), 64'd1);
        check("overflow_err", 64'(overflow_err), 64'(exp_ovf));
        check("in_ready_done", 64'(in_ready), 64'd0);
        check("busy_done", 64'(busy), 64'd0);
        check("final_waddr", 64'(mem_waddr), 64'(n_used - 1));
        check("checksum_final", 64'(checksum), 64'(exp_cs(cs)));
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("in_ready_held_done", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("checksum_frozen", 64'(checksum), 64'(exp_cs(cs)));
    endtask

    function automatic logic [31:0] rand_nonhalt();
        logic [31:0] r;
        r = $urandom();
        if (r[31:26] == 6'h3F) r[26] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] rand_halt();
        logic [31:0] r;
        r = $urandom();
        return {6'h3F, r[25:0]};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset with a byte offered.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        check("rst_waddr", 64'(mem_waddr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Directed: one word then a halt word.
        stim_words = '{32'h12345678, 32'hFC000000};
        run_load();

        // Fill memory with non-halt words.
        stim_words.delete();
        for (int i = 0; i < DEPTH; i++) stim_words.push_back(rand_nonhalt());
        run_load();

        // Random loads, each ending in a halt, restarted from DONE.
        for (int k = 0; k < 6; k++) begin
            stim_words.delete();
            n = $urandom_range(1, 30);
            for (int i = 0; i < n - 1; i++) begin
                if ($urandom_range(0, 9) == 0) stim_words.push_back(rand_halt());
                else                           stim_words.push_back(rand_nonhalt());
            end
            stim_words.push_back(rand_halt());
            run_load();
        end

        // Reset after two bytes of a word: nothing written, back to idle.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_mem_we", 64'(mem_we), 64'd0);
        check("midrst_waddr", 64'(mem_waddr), 64'd0);
        check("midrst_checksum", 64'(checksum), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 64'({in_ready, busy, done, mem_we}), 64'd0);
            @(posedge clk); #1;
        end

        stim_words = '{rand_nonhalt(), rand_halt()};
        run_load();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
